// File: rtl/updown_counter_param.sv
// Up/down counter over 0..limit with load, step, wrap/saturate, terminal count and sticky overflow.
// Optional macro COUNTER_PRESCALE_EN adds a prescale input that divides the enabled count rate.
module updown_counter_param #(
  parameter int WIDTH      = 8,
  parameter int STEP_W     = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_data,
  input  logic [STEP_W-1:0]     step,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  sat_mode,
  input  logic                  clr_ovf,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  at_zero,
  output logic                  at_limit,
  output logic                  ovf
);

  // One spare bit over the widest operand keeps every sum and difference exact.
  localparam int MW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  if (WIDTH < 1 || STEP_W < 1 || PRESCALE_W < 1) begin : g_param_check
    $error("updown_counter_param: all widths must be at least 1");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             at_zero_q, at_zero_d;
  logic             at_limit_q, at_limit_d;
  logic             tick;

  logic [MW-1:0] cnt_x, lim_x, step_x, ld_x, s_x, sum_x;

  assign cnt_x  = MW'(cnt_q);
  assign lim_x  = MW'(limit);
  assign step_x = MW'(step);
  assign ld_x   = MW'(load_data);
  assign s_x    = (step_x > lim_x) ? lim_x : step_x;
  assign sum_x  = cnt_x + s_x;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  // Using >= lets a prescale value lowered mid-interval take effect at once.
  always_comb begin
    psc_d = psc_q;
    tick  = (psc_q >= prescale);
    if (load) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    cnt_d = cnt_q;
    evt_d = 1'b0;
    if (load) begin
      if (ld_x > lim_x) begin
        cnt_d = limit;
        evt_d = 1'b1;
      end else begin
        cnt_d = load_data;
      end
    end else if (en && (cnt_x > lim_x)) begin
      cnt_d = limit;
      evt_d = 1'b1;
    end else if (en && tick && (s_x != '0)) begin
      if (!up_down) begin
        if (sum_x <= lim_x) begin
          cnt_d = WIDTH'(sum_x);
        end else begin
          evt_d = 1'b1;
          cnt_d = sat_mode ? limit : WIDTH'(sum_x - lim_x - MW'(1));
        end
      end else begin
        if (s_x <= cnt_x) begin
          cnt_d = WIDTH'(cnt_x - s_x);
        end else begin
          evt_d = 1'b1;
          cnt_d = sat_mode ? '0 : WIDTH'(cnt_x + lim_x + MW'(1) - s_x);
        end
      end
    end
  end

  // A new event wins over a simultaneous clear so no overflow is ever lost.
  always_comb begin
    ovf_d      = evt_d | (ovf_q & ~clr_ovf);
    count_d    = cnt_q;
    tc_d       = evt_q;
    at_zero_d  = (cnt_q == '0);
    at_limit_d = (cnt_q == limit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      evt_q      <= 1'b0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      tc_q       <= 1'b0;
      at_zero_q  <= 1'b1;
      at_limit_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      tc_q       <= tc_d;
      at_zero_q  <= at_zero_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign at_zero  = at_zero_q;
  assign at_limit = at_limit_q;
  assign ovf      = ovf_q;

endmodule
